// File: rtl/p2s_rr_arbiter.sv
// ---------------------------------------------------------------------------
// p2s_rr_arbiter
//   Round-robin arbiter that shares one parallel-to-serial converter between
//   M parallel-word requesters. One requester is granted at a time for a burst
//   of up to BURST words. Priority then rotates so that the previous grantee
//   becomes the lowest-priority requester.
//
// Ports
//   clk      in   1     rising-edge clock
//   rstn     in   1     asynchronous active-low reset
//   s_data   in   M*N   requester words, requester i at [i*N +: N]
//   s_valid  in   M     per-requester valid
//   s_ready  out  M     per-requester ready (at most one bit high)
//   m_data   out  N     word towards p2s par_data
//   m_valid  out  1     towards p2s par_valid
//   m_ready  in   1     from p2s par_ready
//   m_id     out  IDW   index of the granted requester (valid with m_valid)
// ---------------------------------------------------------------------------
module p2s_rr_arbiter #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int BURST = 4,
  localparam int IDW  = $clog2(M)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [M*N-1:0]   s_data,
  input  logic [M-1:0]     s_valid,
  output logic [M-1:0]     s_ready,
  output logic [N-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IDW-1:0]   m_id
);

  localparam int CNTW = $clog2(BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_r;
  logic [IDW-1:0]  grant_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [CNTW-1:0] beat_cnt_r;

  logic [N-1:0]    words_s [M];
  logic [IDW-1:0]  pick_s;
  logic [IDW-1:0]  next_ptr_s;
  logic            gnt_valid_s;
  logic            xfer_s;
  logic            release_s;

  // First requesting index found when scanning ptr, ptr+1, ... modulo M.
  function automatic logic [IDW-1:0] rr_pick(input logic [M-1:0]   req,
                                             input logic [IDW-1:0] ptr);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < M; k++) begin
      idx = IDW'((int'(ptr) + k) % M);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Split the flat requester bus into per-requester words.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      words_s[i] = s_data[i*N +: N];
    end
  end

  // Arbitration, transfer and release decode.
  always_comb begin
    pick_s      = rr_pick(s_valid, rr_ptr_r);
    gnt_valid_s = s_valid[grant_r];
    xfer_s      = (state_r == GRANT) && gnt_valid_s && m_ready;
    // A missing word ends the grant immediately; otherwise the last beat does.
    release_s   = (state_r == GRANT) &&
                  (!gnt_valid_s || (xfer_s && (beat_cnt_r == CNTW'(BURST - 1))));
    if (grant_r == IDW'(M - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_r + IDW'(1);
    end
  end

  // Output muxing from the registered grant; everything is zero while idle.
  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    m_id    = '0;
    s_ready = '0;
    if (state_r == GRANT) begin
      m_data           = words_s[grant_r];
      m_valid          = gnt_valid_s;
      m_id             = grant_r;
      s_ready[grant_r] = m_ready;
    end else begin
      m_data  = '0;
    end
  end

  // Grant state machine, rotating pointer and beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|s_valid) begin
            grant_r    <= pick_s;
            beat_cnt_r <= '0;
            state_r    <= GRANT;
          end
        end
        GRANT: begin
          if (release_s) begin
            rr_ptr_r   <= next_ptr_s;
            beat_cnt_r <= '0;
            state_r    <= IDLE;
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + CNTW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_p2s_rr_arbiter
//   Self-checking bench for p2s_rr_arbiter (M=4, N=8, BURST=2). A behavioural
//   model tracks the current owner, words sent and the last grantee; priority
//   is the circular distance from the last grantee. Outputs are compared with
//   the model every cycle, and directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_p2s_rr_arbiter;

  localparam int N     = 8;
  localparam int M     = 4;
  localparam int BURST = 2;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [M*N-1:0]   s_data;
  logic [M-1:0]     s_valid;
  logic [M-1:0]     s_ready;
  logic [N-1:0]     m_data;
  logic             m_valid;
  logic             m_ready;
  logic [IDW-1:0]   m_id;

  int checks = 0;
  int errors = 0;

  // model: owner = -1 when idle
  int owner;
  int sent;
  int last;

  int seq2 [14] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};

  p2s_rr_arbiter #(.N(N), .M(M), .BURST(BURST)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_id    (m_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    sent  = 0;
    last  = M - 1;
  endtask

  // Requester with the smallest circular distance after the last grantee.
  function automatic int model_pick(input logic [M-1:0] v);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = M;
    for (int i = 0; i < M; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + 2 * M) % M;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_advance();
    if (!rstn) begin
      model_reset();
    end else if (owner < 0) begin
      if (s_valid != '0) begin
        owner = model_pick(s_valid);
        sent  = 0;
      end
    end else if (!s_valid[owner]) begin
      last  = owner;
      owner = -1;
    end else if (m_ready) begin
      sent++;
      if (sent == BURST) begin
        last  = owner;
        owner = -1;
      end
    end
  endtask

  task automatic compare_now();
    logic [N-1:0] ed;
    logic [M-1:0] er;
    if (owner < 0) begin
      chk("model m_valid", m_valid, 0);
      chk("model s_ready", s_ready, 0);
      chk("model m_id", m_id, 0);
      chk("model m_data", m_data, 0);
    end else begin
      ed = s_data[owner*N +: N];
      er = m_ready ? (M'(1) << owner) : '0;
      chk("model m_valid", m_valid, s_valid[owner]);
      chk("model s_ready", s_ready, er);
      chk("model m_id", m_id, owner);
      chk("model m_data", m_data, ed);
    end
  endtask

  task automatic check();
    #1;
    compare_now();
  endtask

  task automatic adv();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    s_valid = '0;
    s_data  = '0;
    m_ready = 1'b0;
    model_reset();
    check(); adv();
    check(); adv();
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b1;
    s_valid = '0;
    s_data  = '0;
    m_ready = 1'b0;
    #2;

    // 1: single requester 2
    do_reset();
    s_data[2*N +: N] = 8'h3E;
    s_valid = 4'b0100;
    m_ready = 1'b1;
    check(); chk("t1 idle m_valid", m_valid, 0); adv();
    check();
    chk("t1 m_valid", m_valid, 1);
    chk("t1 m_id", m_id, 2);
    chk("t1 m_data", m_data, 8'h3E);
    chk("t1 s_ready", s_ready, 4'b0100);
    adv();
    check(); chk("t1 beat2 m_valid", m_valid, 1); adv();
    check(); chk("t1 bubble", m_valid, 0); adv();

    // 2: all requesting continuously
    do_reset();
    s_data  = 32'hA1B2C3D4;
    s_valid = 4'b1111;
    m_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      check();
      if (seq2[k] < 0) begin
        chk("t2 bubble", m_valid, 0);
      end else begin
        chk("t2 m_valid", m_valid, 1);
        chk("t2 m_id", m_id, seq2[k]);
        chk("t2 s_ready", s_ready, 32'(1) << seq2[k]);
      end
      adv();
    end

    // 3: backpressure on requester 1
    do_reset();
    s_data  = '0;
    s_data[1*N +: N] = 8'h55;
    s_valid = 4'b0010;
    m_ready = 1'b1;
    check(); adv();
    check(); chk("t3 m_id", m_id, 1); adv();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check();
      chk("t3 hold m_valid", m_valid, 1);
      chk("t3 hold m_data", m_data, 8'h55);
      chk("t3 hold m_id", m_id, 1);
      chk("t3 hold s_ready", s_ready, 0);
      adv();
    end
    m_ready = 1'b1;
    check(); chk("t3 final s_ready", s_ready, 4'b0010); adv();
    check(); chk("t3 released", m_valid, 0); adv();

    // 4: pointer wrap 3 -> 0
    do_reset();
    m_ready = 1'b1;
    s_valid = 4'b1000;
    check(); chk("t4 idle", m_valid, 0); adv();
    s_valid = 4'b1001;
    check(); chk("t4 id3 a", m_id, 3); adv();
    check(); chk("t4 id3 b", m_id, 3); adv();
    check(); chk("t4 bubble", m_valid, 0); adv();
    check(); chk("t4 m_valid", m_valid, 1); chk("t4 wrap id", m_id, 0); adv();

    // 5: requester 0 drops valid after one word
    do_reset();
    m_ready = 1'b1;
    s_valid = 4'b0001;
    check(); adv();
    s_valid = 4'b0101;
    check(); chk("t5 id0", m_id, 0); chk("t5 valid0", m_valid, 1); adv();
    s_valid = 4'b0100;
    check(); chk("t5 drop", m_valid, 0); adv();
    check(); chk("t5 bubble", m_valid, 0); adv();
    check(); chk("t5 m_valid", m_valid, 1); chk("t5 id2", m_id, 2); adv();

    // 6: async reset mid-burst
    do_reset();
    m_ready = 1'b1;
    s_valid = 4'b0010;
    check(); adv();
    check(); chk("t6 id1", m_id, 1); adv();
    rstn = 1'b0;
    #1;
    chk("t6 async m_valid", m_valid, 0);
    chk("t6 async s_ready", s_ready, 0);
    model_reset();
    s_valid = 4'b0011;
    check(); adv();
    rstn = 1'b1;
    check(); chk("t6 idle", m_valid, 0); adv();
    check(); chk("t6 m_valid", m_valid, 1); chk("t6 first id", m_id, 0); adv();

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < M; i++) begin
        s_valid[i] = ($urandom_range(0, 9) < 7);
      end
      s_data  = $urandom;
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check(); adv();
        rstn = 1'b1;
      end
      check();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
